// File: rtl/aes_pkg.sv
// Shared AES-128 types and GF(2^8) helpers for the iterative encryption datapath.
// The S-box is built from the field inverse plus the affine map, so no ROM table is needed.
package aes_pkg;

    localparam int NR_AES128 = 10;
    localparam int BLK_W     = 128;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse is a^254 (bits 1..7 of the exponent set); 0 maps to 0 naturally.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] sq;
        inv = 8'h01;
        sq  = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) inv = gf_mul(inv, sq);
            sq = gf_mul(sq, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [BLK_W-1:0] sub_bytes(input logic [BLK_W-1:0] st);
        logic [BLK_W-1:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox(st[127-8*i -: 8]);
        return r;
    endfunction

    // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
    function automatic logic [BLK_W-1:0] shift_rows(input logic [BLK_W-1:0] st);
        logic [BLK_W-1:0] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++)
                r[127-8*(rw+4*c) -: 8] = st[127-8*(rw+4*((c+rw)%4)) -: 8];
        return r;
    endfunction

    function automatic logic [BLK_W-1:0] mix_columns(input logic [BLK_W-1:0] st);
        logic [BLK_W-1:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) r[127-32*c -: 32] = mix_column(st[127-32*c -: 32]);
        return r;
    endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One AES encryption round, purely combinational; MixColumns is bypassed on the final round.
module aes_round_comb
    import aes_pkg::*;
(
    input  logic [BLK_W-1:0] st_i,
    input  logic [BLK_W-1:0] rk_i,
    input  logic             last_i,
    output logic [BLK_W-1:0] next_o
);

    logic [BLK_W-1:0] sb;
    logic [BLK_W-1:0] sr;
    logic [BLK_W-1:0] mc;

    assign sb     = sub_bytes(st_i);
    assign sr     = shift_rows(sb);
    assign mc     = mix_columns(sr);
    assign next_o = (last_i ? sr : mc) ^ rk_i;

endmodule

// File: rtl/aes_enc_round_ctrl.sv
// Iterative AES-128 encryption controller: initial key add on accept, then NR rounds on a
// shared round datapath, ciphertext held on a valid/ready port until taken.
module aes_enc_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR    = NR_AES128,
    parameter int RKI_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_data,
    output logic [RKI_W-1:0] rk_idx,
    input  logic [BLK_W-1:0] rk,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_data,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [RKI_W-1:0] round_q, round_d;
    logic [BLK_W-1:0] st_q, st_d;
    logic [BLK_W-1:0] round_next;
    logic             last_round;

    assign last_round = (round_q == RKI_W'(NR));

    aes_round_comb u_round (
        .st_i   (st_q),
        .rk_i   (rk),
        .last_i (last_round),
        .next_o (round_next)
    );

    always_comb begin
        // NOTE: every output gets a default first, so no branch can infer a latch.
        state_d   = state_q;
        round_d   = round_q;
        st_d      = st_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        rk_idx    = '0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    st_d    = in_data ^ rk;
                    round_d = RKI_W'(1);
                    state_d = ROUND;
                end
            end
            ROUND: begin
                rk_idx = round_q;
                st_d   = round_next;
                // Counter stops at NR; the final round leaves it there until DONE is left.
                if (last_round) state_d = DONE;
                else            round_d = round_q + RKI_W'(1);
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                    round_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments for all registered state; blocking only in always_comb.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            round_q <= '0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            st_q    <= st_d;
        end
    end

    assign out_data = st_q;
    assign busy     = (state_q != IDLE);

endmodule
